// File: rtl/async_fifo_pkg.sv
// Shared helpers for the Gray-pointer dual-clock FIFO.
// Provides pointer-width derivation and binary/Gray conversions.
package async_fifo_pkg;

    // Conversions work on zero-extended values, so one 32-bit body serves any pointer width up to 32.
    localparam int GRAY_MAXW = 32;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
        logic [GRAY_MAXW-1:0] b;
        b = g;
        for (int i = 1; i < GRAY_MAXW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_gray_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into i_clk.
// Only one bit changes per pointer step, so a stale sample is never a corrupt one.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointers, registered flags, fill levels
// and sticky overflow/underflow. All DEPTH entries are usable.
module async_fifo_gray
    import async_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk_write,
    input  logic                     clk_read,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     write_enable,
    input  logic                     read_enable,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   wr_level,
    output logic [$clog2(DEPTH):0]   rd_level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDRW = addr_width(DEPTH);
    localparam int PW    = ADDRW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write-domain state
    logic [PW-1:0]    r_wbin;
    logic [PW-1:0]    r_wgray;
    logic             r_full;
    logic             r_almost_full;
    logic [PW-1:0]    r_wr_level;
    logic             r_overflow;

    // Read-domain state
    logic [PW-1:0]    r_rbin;
    logic [PW-1:0]    r_rgray;
    logic             r_empty;
    logic             r_almost_empty;
    logic [PW-1:0]    r_rd_level;
    logic             r_underflow;
    logic [WIDTH-1:0] r_data_out;

    logic [PW-1:0]    w_wq2_rptr;
    logic [PW-1:0]    w_rq2_wptr;

    logic             w_wr_accept;
    logic [PW-1:0]    w_wbin_next;
    logic [PW-1:0]    w_wgray_next;
    logic [PW-1:0]    w_wq2_rbin;
    logic [PW-1:0]    w_wr_level_next;
    logic             w_full_next;

    logic             w_rd_accept;
    logic [PW-1:0]    w_rbin_next;
    logic [PW-1:0]    w_rgray_next;
    logic [PW-1:0]    w_rq2_wbin;
    logic [PW-1:0]    w_rd_level_next;
    logic             w_empty_next;

    sync_2ff #(.WIDTH(PW)) u_sync_r2w (
        .i_clk   (clk_write),
        .i_rst_n (rst),
        .i_d     (r_rgray),
        .o_q     (w_wq2_rptr)
    );

    sync_2ff #(.WIDTH(PW)) u_sync_w2r (
        .i_clk   (clk_read),
        .i_rst_n (rst),
        .i_d     (r_wgray),
        .o_q     (w_rq2_wptr)
    );

    // Write side: flags and level look at the post-increment pointer so they update on the accepting edge.
    assign w_wr_accept     = write_enable && !r_full;
    assign w_wbin_next     = r_wbin + PW'(w_wr_accept);
    assign w_wgray_next    = PW'(bin2gray(GRAY_MAXW'(w_wbin_next)));
    assign w_wq2_rbin      = PW'(gray2bin(GRAY_MAXW'(w_wq2_rptr)));
    assign w_wr_level_next = w_wbin_next - w_wq2_rbin;
    assign w_full_next     = (w_wgray_next == {~w_wq2_rptr[PW-1:PW-2], w_wq2_rptr[PW-3:0]});

    always_ff @(posedge clk_write) begin
        if (w_wr_accept) begin
            r_mem[r_wbin[ADDRW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk_write or negedge rst) begin
        if (!rst) begin
            r_wbin        <= '0;
            r_wgray       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wgray_next;
            r_full        <= w_full_next;
            r_almost_full <= (int'(w_wr_level_next) >= AF_THRESH);
            r_wr_level    <= w_wr_level_next;
            r_overflow    <= r_overflow | (write_enable & r_full);
        end
    end

    assign w_rd_accept     = read_enable && !r_empty;
    assign w_rbin_next     = r_rbin + PW'(w_rd_accept);
    assign w_rgray_next    = PW'(bin2gray(GRAY_MAXW'(w_rbin_next)));
    assign w_rq2_wbin      = PW'(gray2bin(GRAY_MAXW'(w_rq2_wptr)));
    assign w_rd_level_next = w_rq2_wbin - w_rbin_next;
    assign w_empty_next    = (w_rgray_next == w_rq2_wptr);

    always_ff @(posedge clk_read or negedge rst) begin
        if (!rst) begin
            r_rbin         <= '0;
            r_rgray        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_level     <= '0;
            r_underflow    <= 1'b0;
            r_data_out     <= '0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rgray        <= w_rgray_next;
            r_empty        <= w_empty_next;
            r_almost_empty <= (int'(w_rd_level_next) <= AE_THRESH);
            r_rd_level     <= w_rd_level_next;
            r_underflow    <= r_underflow | (read_enable & r_empty);
            if (w_rd_accept) begin
                r_data_out <= r_mem[r_rbin[ADDRW-1:0]];
            end
        end
    end

    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign wr_level     = r_wr_level;
    assign overflow     = r_overflow;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_level     = r_rd_level;
    assign underflow    = r_underflow;
    assign data_out     = r_data_out;

endmodule

// File: tb/tb_async_fifo_gray.sv
// Self-checking bench for async_fifo_gray: directed fill/underflow/wrap/latency
// scenarios plus randomized clock-ratio sweeps against a queue model.
`timescale 1ns/1ps
module tb_async_fifo_gray;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 1;

    logic             clk_write;
    logic             clk_read;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             write_enable;
    logic             read_enable;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             almost_full;
    logic             empty;
    logic             almost_empty;
    logic [LW-1:0]    wr_level;
    logic [LW-1:0]    rd_level;
    logic             overflow;
    logic             underflow;

    realtime wr_half = 5.0;
    realtime rd_half = 8.5;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: words accepted but not yet read, in order.
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_dout;

    int rd_edges = 0;
    int wr_edges = 0;
    int snap_r   = 0;
    int snap_w   = 0;
    bit prod_done;

    async_fifo_gray #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk_write    (clk_write),
        .clk_read     (clk_read),
        .rst          (rst),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .wr_level     (wr_level),
        .rd_level     (rd_level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk_write = 1'b0;
        forever #(wr_half) clk_write = ~clk_write;
    end

    initial begin
        clk_read = 1'b0;
        #1;
        forever #(rd_half) clk_read = ~clk_read;
    end

    always @(posedge clk_read)  rd_edges++;
    always @(posedge clk_write) wr_edges++;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One write-domain cycle; a write is accepted by the FIFO only when full is low.
    task automatic wr_cycle(input bit en, input logic [WIDTH-1:0] d);
        bit acc;
        write_enable = en;
        data_in      = d;
        acc          = en && !full;
        @(posedge clk_write);
        snap_r = rd_edges;
        #1;
        write_enable = 1'b0;
        if (acc) model_q.push_back(d);
        check_val("wr_lvl_ge_occ", int'(int'(wr_level) >= model_q.size()), 1);
        check_val("full_rule", int'(full), int'(int'(wr_level) == DEPTH));
        check_val("af_rule", int'(almost_full), int'(int'(wr_level) >= AF));
    endtask

    // One read-domain cycle; data_out must show the oldest word after an accepted read, else hold.
    task automatic rd_cycle(input bit en);
        bit acc;
        read_enable = en;
        acc         = en && !empty;
        @(posedge clk_read);
        snap_w = wr_edges;
        #1;
        read_enable = 1'b0;
        if (acc) begin
            if (model_q.size() == 0) check_val("rd_model_nonempty", 0, 1);
            else exp_dout = model_q.pop_front();
        end
        check_val("data_out", int'(data_out), int'(exp_dout));
        check_val("rd_lvl_le_occ", int'(int'(rd_level) <= model_q.size()), 1);
        check_val("empty_rule", int'(empty), int'(int'(rd_level) == 0));
        check_val("ae_rule", int'(almost_empty), int'(int'(rd_level) <= AE));
    endtask

    task automatic do_reset(input realtime wh, input realtime rh);
        rst          = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        wr_half      = wh;
        rd_half      = rh;
        repeat (2) @(posedge clk_read);
        repeat (2) @(posedge clk_write);
        #1;
        model_q.delete();
        exp_dout = '0;
        check_val("rst_empty", int'(empty), 1);
        check_val("rst_ae", int'(almost_empty), 1);
        check_val("rst_full", int'(full), 0);
        check_val("rst_af", int'(almost_full), 0);
        check_val("rst_wr_level", int'(wr_level), 0);
        check_val("rst_rd_level", int'(rd_level), 0);
        check_val("rst_data_out", int'(data_out), 0);
        check_val("rst_overflow", int'(overflow), 0);
        check_val("rst_underflow", int'(underflow), 0);
        @(negedge clk_write);
        #0.3;
        rst = 1'b1;
    endtask

    task automatic run_sweep(input int n_wr, input int rd_budget);
        prod_done = 1'b0;
        fork
            begin : producer
                for (int k = 0; k < n_wr; k++) begin
                    wr_cycle(($urandom_range(0, 1) == 1) && !full, WIDTH'($urandom));
                end
                prod_done = 1'b1;
            end
            begin : consumer
                int budget;
                budget = rd_budget;
                while (!(prod_done && model_q.size() == 0) && budget > 0) begin
                    budget--;
                    rd_cycle(($urandom_range(0, 1) == 1) && !empty);
                end
                check_val("sweep_drained", model_q.size(), 0);
            end
        join
        check_val("sweep_overflow", int'(overflow), 0);
        check_val("sweep_underflow", int'(underflow), 0);
    endtask

    initial begin
        rst          = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        data_in      = '0;
        exp_dout     = '0;
        do_reset(5.0, 8.5);

        // Fill to capacity with no reads, then one dropped write.
        for (int i = 0; i < DEPTH; i++) begin
            wr_cycle(1'b1, WIDTH'(i));
            check_val("fill_lvl", int'(wr_level), i + 1);
            check_val("fill_af", int'(almost_full), int'((i + 1) >= AF));
        end
        check_val("fill_full", int'(full), 1);
        wr_cycle(1'b1, 8'hAA);
        check_val("fill_overflow", int'(overflow), 1);
        check_val("fill_lvl_hold", int'(wr_level), DEPTH);
        repeat (4) @(posedge clk_read);
        #1;
        check_val("fill_rd_level", int'(rd_level), DEPTH);
        for (int i = 0; i < DEPTH; i++) rd_cycle(1'b1);
        check_val("drain_last", int'(data_out), 8'h0F);
        repeat (4) rd_cycle(1'b0);
        check_val("drain_empty", int'(empty), 1);
        repeat (4) wr_cycle(1'b0, '0);
        check_val("drain_wr_level", int'(wr_level), 0);
        check_val("drain_full", int'(full), 0);

        // Underflow: read while empty leaves data_out and level untouched.
        check_val("unf_before", int'(underflow), 0);
        rd_cycle(1'b1);
        check_val("unf_flag", int'(underflow), 1);
        check_val("unf_dout", int'(data_out), 8'h0F);
        check_val("unf_rd_level", int'(rd_level), 0);

        // Wrap-around: 40 interleaved transfers, kept well below full.
        fork
            begin : wrap_prod
                int i;
                int budget;
                i = 0;
                budget = 3000;
                while (i < 40 && budget > 0) begin
                    budget--;
                    if (int'(wr_level) < 8 && $urandom_range(0, 1) == 1) begin
                        wr_cycle(1'b1, WIDTH'(i));
                        i++;
                    end else begin
                        wr_cycle(1'b0, '0);
                    end
                    check_val("wrap_no_full", int'(full), 0);
                end
                check_val("wrap_prod_count", i, 40);
            end
            begin : wrap_cons
                int got;
                int budget;
                got = 0;
                budget = 3000;
                while (got < 40 && budget > 0) begin
                    budget--;
                    if (!empty && $urandom_range(0, 1) == 1) begin
                        rd_cycle(1'b1);
                        got++;
                    end else begin
                        rd_cycle(1'b0);
                    end
                end
                check_val("wrap_cons_count", got, 40);
                check_val("wrap_last", int'(data_out), 39);
            end
        join
        repeat (5) wr_cycle(1'b0, '0);

        // Latency: single word through an idle FIFO.
        begin : latency
            int budget;
            wr_cycle(1'b1, 8'h5C);
            budget = 10;
            while (empty && budget > 0) begin
                @(posedge clk_read);
                #1;
                budget--;
            end
            check_val("lat_empty_le3", int'(!empty && (rd_edges - snap_r) <= 3), 1);
            check_val("lat_rd_level", int'(rd_level), 1);
            rd_cycle(1'b1);
            check_val("lat_data", int'(data_out), 8'h5C);
            budget = 10;
            while (int'(wr_level) != 0 && budget > 0) begin
                @(posedge clk_write);
                #1;
                budget--;
            end
            check_val("lat_wr_level_le3", int'(int'(wr_level) == 0 && (wr_edges - snap_w) <= 3), 1);
        end

        // Mid-stream reset discards contents and restores every output.
        for (int i = 0; i < 3; i++) wr_cycle(1'b1, WIDTH'(8'h30 + i));
        repeat (4) @(posedge clk_read);
        #1;
        rd_cycle(1'b1);
        check_val("mid_data", int'(data_out), 8'h30);
        do_reset(5.0, 1.5);

        // Fast reader, slow writer.
        run_sweep(2500, 20000);

        // Fast writer, slow reader.
        do_reset(1.5, 5.0);
        run_sweep(8000, 10000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
